// File: rtl/fir_output_quantizer.sv
// Purpose: round/scale/saturate the FIR accumulator sum into OUTBITS samples behind a FWFT output FIFO.
// Latency: capture edge N -> stage-1 register; FIFO write at N+1; out_valid visible after N+1 when empty.
// Backpressure: out_valid/out_ready; a result arriving at a full FIFO with no pop is dropped (drop pulse).
// Build option: define FIR_ROUND_EN for round-half-up; otherwise plain floor truncation.
module fir_output_quantizer #(
    parameter int ACCUBITS = 41,
    parameter int OUTBITS  = 16,
    parameter int SHIFT    = 15,
    parameter int LAT      = 9,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ACCUBITS-1:0] acc_in,
    input  logic                clr_flags,
    output logic [OUTBITS-1:0]  out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sat_flag,
    output logic                drop
);

    localparam int CW = $clog2(LAT + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] LAT_C   = CW'(LAT);
    localparam logic [NW-1:0] DEPTH_C = NW'(DEPTH);

    // Output range limits expressed at the widened stage-1 width.
    localparam logic signed [ACCUBITS:0] SAT_MAX =
        {{(ACCUBITS + 2 - OUTBITS){1'b0}}, {(OUTBITS - 1){1'b1}}};
    localparam logic signed [ACCUBITS:0] SAT_MIN =
        {{(ACCUBITS + 2 - OUTBITS){1'b1}}, {(OUTBITS - 1){1'b0}}};

    logic [CW-1:0]             prime_cnt;
    logic                      capture;
    logic signed [ACCUBITS:0]  acc_ext;
    logic signed [ACCUBITS:0]  acc_rnd;
    logic signed [ACCUBITS:0]  acc_scaled;
    logic signed [ACCUBITS:0]  s1_val;
    logic                      s1_valid;
    logic [OUTBITS-1:0]        s2_dat;
    logic                      s2_sat;

    logic [OUTBITS-1:0]        mem [DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [NW-1:0]             fifo_cnt;
    logic                      fifo_full;
    logic                      rd_en;
    logic                      wr_en;
    logic                      wr_drop;

    // A strobe only carries a real result once the adder tree has filled.
    assign capture = in_valid && (prime_cnt == LAT_C);

    // One extra bit of headroom so the rounding add can never wrap.
    assign acc_ext = {acc_in[ACCUBITS-1], acc_in};

`ifdef FIR_ROUND_EN
    localparam logic signed [ACCUBITS:0] RND_C =
        {{ACCUBITS{1'b0}}, 1'b1} << (SHIFT - 1);
    assign acc_rnd = acc_ext + RND_C;
`else
    assign acc_rnd = acc_ext;
`endif

    assign acc_scaled = acc_rnd >>> SHIFT;

    // Prime counter: counts strobes up to the tree depth, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
        end else if (in_valid && (prime_cnt != LAT_C)) begin
            prime_cnt <= prime_cnt + CW'(1);
        end
    end

    // Stage 1: register the scaled value on capture strobes only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_val <= acc_scaled;
            end
        end
    end

    // Stage 2: clamp the scaled value to the signed output range.
    always_comb begin
        s2_sat = 1'b0;
        s2_dat = s1_val[OUTBITS-1:0];
        if (s1_val > SAT_MAX) begin
            s2_sat = 1'b1;
            s2_dat = {1'b0, {(OUTBITS - 1){1'b1}}};
        end else if (s1_val < SAT_MIN) begin
            s2_sat = 1'b1;
            s2_dat = {1'b1, {(OUTBITS - 1){1'b0}}};
        end
    end

    // Sticky saturation flag; a new saturation beats a same-edge clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (s1_valid && s2_sat) begin
            sat_flag <= 1'b1;
        end else if (clr_flags) begin
            sat_flag <= 1'b0;
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign fifo_full = (fifo_cnt == DEPTH_C);
    assign rd_en     = out_valid && out_ready;
    // A pop on the same edge frees the slot for the incoming result.
    assign wr_en     = s1_valid && (!fifo_full || rd_en);
    assign wr_drop   = s1_valid && fifo_full && !rd_en;

    // Output FIFO: wrap-around pointers, occupancy count and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            drop     <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= s2_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + NW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - NW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            drop <= wr_drop;
        end
    end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// Scoreboard bench for fir_output_quantizer: directed test-plan cases plus random traffic.
// Expected samples come from plain integer arithmetic (floor division, clamp) and a FIFO occupancy model.
// A monitor on the falling edge compares DUT outputs with the expected queue head.
module tb_fir_output_quantizer;

    localparam int ACCUBITS = 41;
    localparam int OUTBITS  = 16;
    localparam int SHIFT    = 15;
    localparam int LAT      = 9;
    localparam int DEPTH    = 4;
    localparam longint SMAX = 32767;
    localparam longint SMIN = -32768;

`ifdef FIR_ROUND_EN
    localparam int RPOS = 2;
    localparam int RNEG = -1;
`else
    localparam int RPOS = 1;
    localparam int RNEG = -2;
`endif

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                in_valid  = 1'b0;
    logic [ACCUBITS-1:0] acc_in    = '0;
    logic                clr_flags = 1'b0;
    logic                out_ready = 1'b0;
    logic [OUTBITS-1:0]  out_data;
    logic                out_valid;
    logic                sat_flag;
    logic                drop;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int  exp_q[$];
    int  occ      = 0;
    int  strobes  = 0;
    bit  pend_vld = 1'b0;
    int  pend_val = 0;
    bit  pend_sat = 1'b0;
    bit  exp_drop = 1'b0;
    bit  exp_sat  = 1'b0;
    int  drop_seen = 0;

    always #5 clk = ~clk;

    fir_output_quantizer #(
        .ACCUBITS(ACCUBITS), .OUTBITS(OUTBITS), .SHIFT(SHIFT), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .acc_in    (acc_in),
        .clr_flags (clr_flags),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .drop      (drop)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scale by 2^SHIFT with floor semantics (optionally adding half an LSB first).
    function automatic longint ref_scale(input longint a);
        longint d;
        longint q;
        d = longint'(1) << SHIFT;
`ifdef FIR_ROUND_EN
        a = a + d / 2;
`endif
        q = a / d;
        if (a < 0 && (a % d) != 0) q = q - 1;
        return q;
    endfunction

    function automatic longint rnd_acc();
        longint v;
        case ($urandom_range(0, 3))
            0: v = longint'($urandom_range(0, 1 << 23)) - (longint'(1) << 22);
            1: v = longint'($urandom_range(0, 1 << 17)) - 65536 +
                   ($urandom_range(0, 1) != 0 ? longint'(32767) * 32768 : longint'(-32768) * 32768);
            2: begin
                v = {$urandom, $urandom};
                v = v >>> (64 - ACCUBITS);
            end
            default: v = (longint'($urandom_range(0, 4000)) - 2000) * 16384;
        endcase
        return v;
    endfunction

    task automatic step(input bit iv, input longint acc, input bit rdy, input bit clr = 1'b0);
        in_valid  = iv;
        acc_in    = acc[ACCUBITS-1:0];
        out_ready = rdy;
        clr_flags = clr;
        @(posedge clk);
        #2;
    endtask

    // Reference model: advances at each rising edge from the inputs presented before it.
    initial begin
        bit     pop;
        bit     push;
        longint q;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                occ      = 0;
                strobes  = 0;
                pend_vld = 1'b0;
                exp_drop = 1'b0;
                exp_sat  = 1'b0;
            end else begin
                pop      = (occ > 0) && out_ready;
                push     = 1'b0;
                exp_drop = 1'b0;
                if (pend_vld) begin
                    if (occ == DEPTH && !pop) begin
                        exp_drop = 1'b1;
                    end else begin
                        exp_q.push_back(pend_val);
                        push = 1'b1;
                    end
                end
                if (pend_vld && pend_sat) exp_sat = 1'b1;
                else if (clr_flags)       exp_sat = 1'b0;
                occ = occ - int'(pop) + int'(push);
                pend_vld = 1'b0;
                if (in_valid) begin
                    if (strobes == LAT) begin
                        q        = ref_scale(longint'($signed(acc_in)));
                        pend_sat = (q > SMAX) || (q < SMIN);
                        if (q > SMAX) q = SMAX;
                        if (q < SMIN) q = SMIN;
                        pend_val = int'(q);
                        pend_vld = 1'b1;
                    end else begin
                        strobes++;
                    end
                end
            end
        end
    end

    // Monitor: checks flags every cycle and the FIFO head whenever out_valid is high.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, occ != 0);
            chk("drop", drop, exp_drop);
            chk("sat_flag", sat_flag, exp_sat);
            if (drop) drop_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: got out_data %0d, expected no output", $signed(out_data));
                end else begin
                    chk("out_data", $signed(out_data), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;

        // Priming: nine fill strobes, then the first real result
        for (int i = 0; i < LAT; i++) step(1'b1, 0, 1'b1);
        chk("prime_no_valid", out_valid, 0);
        step(1'b1, 32768, 1'b1);
        chk("prime_not_yet", out_valid, 0);
        step(1'b0, 0, 1'b1);
        chk("prime_valid", out_valid, 1);
        chk("prime_data", $signed(out_data), 1);
        step(1'b0, 0, 1'b1);

        // Rounding of +/- 1.5 LSB
        step(1'b1, 49152, 1'b1);
        step(1'b1, -49152, 1'b1);
        chk("round_pos", $signed(out_data), RPOS);
        step(1'b0, 0, 1'b1);
        chk("round_neg", $signed(out_data), RNEG);
        step(1'b0, 0, 1'b1);

        // Saturation in both directions, sticky flag and clear
        step(1'b1, longint'(1) << 31, 1'b1);
        step(1'b1, -(longint'(1) << 31), 1'b1);
        chk("sat_pos", $signed(out_data), 32767);
        step(1'b0, 0, 1'b1);
        chk("sat_neg", $signed(out_data), -32768);
        chk("sat_flag_set", sat_flag, 1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("sat_flag_hold", sat_flag, 1);
        step(1'b0, 0, 1'b1, 1'b1);
        chk("sat_flag_clr", sat_flag, 0);

        // Backpressure: five results into a four-deep FIFO
        d0 = drop_seen;
        for (int v = 1; v <= 5; v++) step(1'b1, longint'(v) << 15, 1'b0);
        repeat (3) step(1'b0, 0, 1'b0);
        chk("bp_drop_count", drop_seen - d0, 1);
        chk("bp_head", $signed(out_data), 1);
        repeat (4) step(1'b0, 0, 1'b1);
        chk("bp_drained", out_valid, 0);

        // Full FIFO with simultaneous pop and push
        for (int v = 1; v <= 4; v++) step(1'b1, longint'(v) << 15, 1'b0);
        step(1'b0, 0, 1'b0);
        d0 = drop_seen;
        step(1'b1, longint'(7) << 15, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("full_rw_no_drop", drop_seen - d0, 0);
        chk("full_rw_head", $signed(out_data), 2);
        repeat (4) step(1'b0, 0, 1'b1);
        chk("full_rw_drained", out_valid, 0);

        // Reset with three buffered entries, then re-prime
        for (int v = 1; v <= 3; v++) step(1'b1, longint'(v + 10) << 15, 1'b0);
        repeat (2) step(1'b0, 0, 1'b0);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) step(1'b1, rnd_acc(), 1'b1);
        chk("reprime_no_valid", out_valid, 0);
        step(1'b1, longint'(3) << 15, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("reprime_valid", out_valid, 1);
        chk("reprime_data", $signed(out_data), 3);

        // Random traffic with random backpressure and flag clears
        repeat (3000) begin
            step($urandom_range(0, 9) < 7, rnd_acc(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0);
        end
        repeat (12) step(1'b0, 0, 1'b1);
        chk("final_sb_empty", exp_q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_output_quantizer.md
# fir_output_quantizer

Downstream stage of the FIR datapath that consumes the wide signed sum produced by the adder-tree accumulator. It tracks the accumulator's fill latency and captures only valid results. It then rounds, scales and saturates each result to the output sample width. Results are buffered in a small FIFO behind a valid/ready handshake toward the DAC/stream sink.

## Interface
Parameters:
- ACCUBITS, 41: width of the signed accumulator sum (MULTBITS + clog2(TAPS)).
- OUTBITS, 16: width of the signed output sample.
- SHIFT, 15: arithmetic right shift applied to the sum (coefficient fraction bits); 1 ≤ SHIFT < ACCUBITS.
- LAT, 9: number of in_valid strobes before acc_in holds a valid result (adder-tree depth).
- DEPTH, 4: output FIFO entries, power of 2, ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  sample strobe; the same signal that advances the accumulator tree.
- acc_in  in  ACCUBITS  signed accumulator sum, two's complement.
- clr_flags  in  1  synchronous clear of sat_flag.
- out_data  out  OUTBITS  FIFO head, signed.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  sink accepts out_data when out_valid && out_ready.
- sat_flag  out  1  sticky; set when any result saturated.
- drop  out  1  one-cycle pulse; a result was discarded because the FIFO was full.

## Operation
- Prime counter: counts in_valid strobes and saturates at LAT. A strobe on an edge where the count already equals LAT is a capture strobe; acc_in is sampled on that edge.
- Stage 1, registered on the capture edge: scale acc_in by an arithmetic right shift of SHIFT, computed at ACCUBITS+1 bits with no intermediate overflow. Rounding mode per Configuration. Sets s1_valid.
- Stage 2, combinational on the stage-1 register:
  - Value > 2^(OUTBITS-1)-1 saturates to 2^(OUTBITS-1)-1.
  - Value < -2^(OUTBITS-1) saturates to -2^(OUTBITS-1).
  - On saturation, sat_flag sets on the write edge.
- FIFO write: on the edge after the capture edge when s1_valid=1.
- FIFO read: on any edge where out_valid && out_ready.
- Full and write without read: the result is discarded, drop=1 for one cycle, and FIFO contents are unchanged.
- Full with simultaneous read and write: both are performed, count stays DEPTH, no drop.
- Empty with write: read is ignored that cycle; the entry appears next cycle.
- FIFO is first-word-fall-through with wrap-around read/write pointers; order is preserved.
- sat_flag: cleared by clr_flags. If set and clear occur on the same edge, set wins.
- Non-capture cycles: stage 1 keeps s1_valid=0 and the FIFO is untouched.

## Timing
- Reset values: out_data=0, out_valid=0, sat_flag=0, drop=0. Prime count=0, s1_valid=0, FIFO empty.
- Reset mid-operation clears all of the above immediately. Buffered results are lost. After release, LAT strobes are needed before the next capture.
- Latency: capture edge N → FIFO write at edge N+1 → out_valid=1 after edge N+1 when the FIFO was empty.
- Throughput: one result per cycle when in_valid is held high and out_ready=1.
- drop asserts in the cycle following the discarding edge and deasserts one cycle later unless another drop occurs.
- out_data is stable while out_valid=1 and out_ready=0.

## Configuration
- FIR_ROUND_EN defined: round half up. Add 2^(SHIFT-1) before the arithmetic shift.
- FIR_ROUND_EN undefined: truncate. Plain arithmetic shift (floor toward −∞), and the adder is removed.
- Saturation, FIFO and flags behave identically in both builds.

## Test plan
- Priming: 9 strobes with acc_in=0 produce no out_valid. The 10th strobe with acc_in=32768 gives out_valid=1 after 2 edges and out_data=1.
- Rounding:
  - acc_in=49152 → 2 with FIR_ROUND_EN, 1 without.
  - acc_in=-49152 → -1 with FIR_ROUND_EN, -2 without.
- Saturation:
  - acc_in=2^31 → out_data=32767 and sat_flag=1, held until a clr_flags pulse clears it.
  - acc_in=-2^31 → -32768.
- Backpressure: out_ready=0 with 5 primed strobes of values 1..5 (×2^15).
  - The FIFO holds 1..4 and drop pulses once for value 5.
  - Then out_ready=1 drains 1,2,3,4 in order and out_valid falls.
- Full with simultaneous read/write: FIFO full, out_ready=1, capture of value 7. Head pops, 7 is enqueued at the tail, and drop=0.
- Reset mid-stream: rst_n low with 3 entries buffered → out_valid=0 immediately. After release, 9 strobes produce no output and the 10th produces output.
